// File: rtl/check_node_min_finder.sv
// Offset-min-sum check-node front end: streams one row of variable-to-check
// messages and reports the two smallest magnitudes, argmin, and sign info.
module check_node_min_finder #(
  parameter int W    = 10,
  parameter int DEG  = 8,
  parameter int IDXW = 3,
  parameter int BETA = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    q_in,
  input  logic            q_valid,
  input  logic            q_last,
  output logic            q_ready,
  output logic [W-2:0]    min1,
  output logic [W-2:0]    min2,
  output logic [IDXW-1:0] min1_idx,
  output logic            sign_prod,
  output logic [DEG-1:0]  signs,
  output logic [IDXW:0]   edge_cnt,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [W-2:0]  MAXMAG = {(W-1){1'b1}};
  localparam logic [IDXW:0] LAST_K = (IDXW+1)'(DEG-1);
  localparam logic [W-1:0]  BETA_W = W'(BETA);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  typedef struct packed {
    logic [W-2:0]    m1;
    logic [W-2:0]    m2;
    logic [IDXW-1:0] idx;
    logic            sp;
    logic [DEG-1:0]  sg;
    logic [IDXW:0]   cnt;
  } acc_t;

  state_t          state_q, state_d;
  acc_t            acc_q, acc_d;
  logic [W-2:0]    min1_q, min1_d, min2_q, min2_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            sp_q, sp_d;
  logic [DEG-1:0]  signs_q, signs_d;
  logic [IDXW:0]   cnt_q, cnt_d;

  logic            in_xfer, out_xfer, first, close;
  logic [IDXW:0]   k_full;
  logic [IDXW-1:0] k;
  logic [W-2:0]    neg, mag;

  // max(raw - BETA, 0), evaluated in W bits so the borrow shows as the sign bit
  function automatic logic [W-2:0] offs(input logic [W-2:0] r);
    logic [W-1:0] d;
    d = {1'b0, r} - BETA_W;
    offs = d[W-1] ? '0 : d[W-2:0];
  endfunction

  always_comb begin
    in_xfer  = q_valid && q_ready;
    out_xfer = out_valid && out_ready;
    first    = (state_q == IDLE);
    k_full   = first ? '0 : acc_q.cnt;
    k        = k_full[IDXW-1:0];
    close    = in_xfer && (q_last || (k_full == LAST_K));
    neg      = (~q_in[W-2:0]) + 1'b1;
    if (!q_in[W-1])              mag = q_in[W-2:0];
    else if (q_in[W-2:0] == '0)  mag = MAXMAG;
    else                         mag = neg;
  end

  always_comb begin
    acc_d = acc_q;
    if (in_xfer) begin
      if (first) begin
        acc_d.m1    = mag;
        acc_d.m2    = MAXMAG;
        acc_d.idx   = '0;
        acc_d.sp    = q_in[W-1];
        acc_d.sg    = '0;
        acc_d.sg[0] = q_in[W-1];
        acc_d.cnt   = (IDXW+1)'(1);
      end else begin
        // strict compare: a tie only fills min2, earliest index keeps min1
        if (mag < acc_q.m1) begin
          acc_d.m2  = acc_q.m1;
          acc_d.m1  = mag;
          acc_d.idx = k;
        end else if (mag < acc_q.m2) begin
          acc_d.m2 = mag;
        end
        acc_d.sp    = acc_q.sp ^ q_in[W-1];
        acc_d.sg[k] = q_in[W-1];
        acc_d.cnt   = acc_q.cnt + 1'b1;
      end
    end
  end

  always_comb begin
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    sp_d    = sp_q;
    signs_d = signs_q;
    cnt_d   = cnt_q;
    if (close) begin
      min1_d  = offs(acc_d.m1);
      min2_d  = offs(acc_d.m2);
      idx_d   = acc_d.idx;
      sp_d    = acc_d.sp;
      signs_d = acc_d.sg;
      cnt_d   = acc_d.cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_xfer) state_d = close ? HOLD : ACCUM;
      ACCUM:   if (close)   state_d = HOLD;
      HOLD:    if (out_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_ready   = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      min1_q  <= '0;
      min2_q  <= '0;
      idx_q   <= '0;
      sp_q    <= 1'b0;
      signs_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sp_q    <= sp_d;
      signs_q <= signs_d;
      cnt_q   <= cnt_d;
    end
  end

  assign min1      = min1_q;
  assign min2      = min2_q;
  assign min1_idx  = idx_q;
  assign sign_prod = sp_q;
  assign signs     = signs_q;
  assign edge_cnt  = cnt_q;

endmodule

// File: tb/tb_check_node_min_finder.sv
// Random and directed rows against a sort-style reference of the row result.
module tb_check_node_min_finder;
  localparam int W = 10, DEG = 8, IDXW = 3, BETA = 1;
  localparam int MAXM = 2**(W-1) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] q_in = '0;
  logic q_valid = 1'b0, q_last = 1'b0, q_ready;
  logic [W-2:0] min1, min2;
  logic [IDXW-1:0] min1_idx;
  logic sign_prod;
  logic [DEG-1:0] signs;
  logic [IDXW:0] edge_cnt;
  logic out_valid, out_ready = 1'b0;

  int errs = 0, checks = 0;

  typedef struct {int m1, m2, idx, sp, signs, cnt;} res_t;

  check_node_min_finder #(.W(W), .DEG(DEG), .IDXW(IDXW), .BETA(BETA)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .q_valid(q_valid), .q_last(q_last),
    .q_ready(q_ready), .min1(min1), .min2(min2), .min1_idx(min1_idx),
    .sign_prod(sign_prod), .signs(signs), .edge_cnt(edge_cnt),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int offs(input int x);
    return (x > BETA) ? x - BETA : 0;
  endfunction

  // Reference: min1 = smallest magnitude (earliest on ties), min2 = smallest of the rest.
  function automatic res_t model(input int v[$]);
    res_t r;
    int mags[$];
    int b1 = 0, second = MAXM;
    foreach (v[i]) mags.push_back(v[i] < 0 ? ((v[i] == -(MAXM+1)) ? MAXM : -v[i]) : v[i]);
    foreach (mags[i]) if (mags[i] < mags[b1]) b1 = i;
    foreach (mags[i]) if (i != b1 && mags[i] < second) second = mags[i];
    r.m1 = offs(mags[b1]); r.m2 = offs(second); r.idx = b1;
    r.sp = 0; r.signs = 0; r.cnt = v.size();
    foreach (v[i]) if (v[i] < 0) begin r.sp ^= 1; r.signs |= (1 << i); end
    return r;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_row(input int v[$], input bit use_last);
    for (int i = 0; i < v.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin q_valid = 1'b0; step(); end
      q_valid = 1'b1;
      q_in    = W'(v[i]);
      q_last  = use_last && (i == v.size() - 1);
      chk("q_ready_accum", q_ready, 1);
      step();
    end
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  task automatic check_out(input res_t e, input string tag);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".q_ready"},   q_ready,   0);
    chk({tag, ".min1"},      min1,      e.m1);
    chk({tag, ".min2"},      min2,      e.m2);
    chk({tag, ".min1_idx"},  min1_idx,  e.idx);
    chk({tag, ".sign_prod"}, sign_prod, e.sp);
    chk({tag, ".signs"},     signs,     e.signs);
    chk({tag, ".edge_cnt"},  edge_cnt,  e.cnt);
  endtask

  // Checks the result, holds it with junk on the input, then releases it.
  task automatic run_row(input int v[$], input bit use_last, input string tag, input int hold);
    res_t e;
    e = model(v);
    send_row(v, use_last);
    check_out(e, tag);
    for (int c = 0; c < hold; c++) begin
      q_valid = 1'b1; q_in = W'($urandom); q_last = 1'(($urandom));
      step();
      check_out(e, {tag, ".hold"});
    end
    q_valid = 1'b0; q_last = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, ".released"}, out_valid, 0);
    chk({tag, ".ready_after"}, q_ready, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".min1"}, min1, 0);
    chk({tag, ".min2"}, min2, 0);
    chk({tag, ".idx"},  min1_idx, 0);
    chk({tag, ".sp"},   sign_prod, 0);
    chk({tag, ".signs"}, signs, 0);
    chk({tag, ".cnt"},  edge_cnt, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
  endtask

  initial begin
    int v[$];
    #1;
    check_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset.q_ready", q_ready, 1);

    v = '{5, -3, 7, -2};              run_row(v, 1, "basic", 1);
    v = '{-512, 511};                 run_row(v, 1, "extreme", 0);
    v = '{4, -4, 9};                  run_row(v, 1, "tie", 2);
    v = '{20, 19, 18, 17, 16, 15, 14, 13}; run_row(v, 0, "forced", 5);

    for (int r = 0; r < 40; r++) begin
      int n;
      bit ul;
      v = {};
      n  = $urandom_range(1, DEG);
      ul = (n < DEG) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
        v.push_back((r % 3 == 0) ? int'($urandom_range(0, 6)) - 3
                                 : int'($urandom_range(0, 1023)) - 512);
      run_row(v, ul, $sformatf("rand%0d", r), $urandom_range(0, 3));
    end

    // Reset mid-row: the partial row and the previous result must vanish.
    v = '{33, -44};
    send_row(v, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    step();
    rst_n = 1'b1;
    step();
    chk("midrst.q_ready", q_ready, 1);
    v = '{0};                         run_row(v, 1, "after_rst", 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
